serial_word_rx: RTL and testbench

Framed serial-to-parallel receiver. It samples one serial bit per `bit_en` strobe and checks the start, parity and stop bits. Each received word is presented on a parallel valid/ready output register, with error flags. It is the receiving end of a link driven by the team's shift register in shift mode, and sits between the serial pin logic and the word-level consumer.

---
 rtl/serial_word_rx.sv | 110 +++++++++++
 tb/tb_serial_word_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_rx.sv
// Framed serial-to-parallel receiver: start/data/parity/stop sampled on bit_en strobes,
// word presented on a valid/ready output register with parity, framing and overrun flags.
module serial_word_rx #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             s_in,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic             acc;
    logic             perr_pend;
    logic             accept;

    assign accept = p_valid & p_ready;

    always_comb begin
        sr_next = sr;
        if (MSB_FIRST != 0) sr_next = {sr[WIDTH-2:0], s_in};
        else                sr_next = {s_in, sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sr         <= '0;
            acc        <= 1'b0;
            perr_pend  <= 1'b0;
            p_data     <= '0;
            p_valid    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            // An accept clears valid; a load later in this block re-asserts it.
            if (accept) p_valid <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (!s_in) begin
                            state     <= DATA;
                            cnt       <= '0;
                            acc       <= 1'b0;
                            perr_pend <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                    DATA: begin
                        sr  <= sr_next;
                        acc <= acc ^ s_in;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1))
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end
                    PARITY: begin
                        if (s_in != (acc ^ 1'(PARITY_ODD))) perr_pend <= 1'b1;
                        state <= STOP;
                    end
                    STOP: begin
                        if (s_in) begin
                            if (!p_valid || accept) begin
                                p_data     <= sr;
                                parity_err <= perr_pend;
                                p_valid    <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                    BREAK: begin
                        if (s_in) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx: three parameterisations (default, odd parity,
// MSB-first without parity) driven by a vector table plus hand-written corner sequences.
module tb_serial_word_rx;

    logic       clk;
    logic       rst;
    logic       bit_en  [3];
    logic       s_in    [3];
    logic       p_ready [3];
    logic [7:0] p_data  [3];
    logic       p_valid [3];
    logic       parity_err [3];
    logic       frame_err  [3];
    logic       overrun    [3];
    logic       busy       [3];

    int n_vec;
    int n_bad;

    serial_word_rx #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(0)) u_def (
        .clk(clk), .rst(rst), .bit_en(bit_en[0]), .s_in(s_in[0]),
        .p_data(p_data[0]), .p_valid(p_valid[0]), .p_ready(p_ready[0]),
        .parity_err(parity_err[0]), .frame_err(frame_err[0]),
        .overrun(overrun[0]), .busy(busy[0]));

    serial_word_rx #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .bit_en(bit_en[1]), .s_in(s_in[1]),
        .p_data(p_data[1]), .p_valid(p_valid[1]), .p_ready(p_ready[1]),
        .parity_err(parity_err[1]), .frame_err(frame_err[1]),
        .overrun(overrun[1]), .busy(busy[1]));

    serial_word_rx #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0), .PARITY_ODD(0)) u_msb (
        .clk(clk), .rst(rst), .bit_en(bit_en[2]), .s_in(s_in[2]),
        .p_data(p_data[2]), .p_valid(p_valid[2]), .p_ready(p_ready[2]),
        .parity_err(parity_err[2]), .frame_err(frame_err[2]),
        .overrun(overrun[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic       par;
        logic [7:0] exp_data;
        logic       exp_perr;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; leaves the strobe high for exactly one rising edge.
    task automatic strobe(input int idx, input logic b, input int gap);
        repeat (gap - 1) @(negedge clk);
        s_in[idx]   = b;
        bit_en[idx] = 1'b1;
        @(negedge clk);
        bit_en[idx] = 1'b0;
    endtask

    task automatic send_frame(input int idx, input logic [7:0] data, input logic par,
                              input logic stop, input int gap);
        strobe(idx, 1'b0, gap);
        for (int i = 0; i < 8; i++)
            strobe(idx, (idx == 2) ? data[7 - i] : data[i], gap);
        if (idx != 2) strobe(idx, par, gap);
        strobe(idx, stop, gap);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        for (int k = 0; k < 3; k++) begin
            bit_en[k]  = 1'b0;
            s_in[k]    = 1'b1;
            p_ready[k] = 1'b1;
        end
        rst = 1'b1;

        vecs[0] = '{0, 8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{0, 8'hA5, 1'b1, 8'hA5, 1'b1};
        vecs[2] = '{1, 8'hA5, 1'b1, 8'hA5, 1'b0};
        vecs[3] = '{1, 8'hA5, 1'b0, 8'hA5, 1'b1};
        vecs[4] = '{2, 8'hC1, 1'b0, 8'hC1, 1'b0};
        vecs[5] = '{0, 8'h01, 1'b1, 8'h01, 1'b0};
        vecs[6] = '{2, 8'h80, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{0, 8'hFF, 1'b1, 8'hFF, 1'b1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_data",  32'(p_data[k]), 32'h0);
            chk("rst_valid", 32'(p_valid[k]), 32'h0);
            chk("rst_busy",  32'(busy[k]), 32'h0);
            chk("rst_perr",  32'(parity_err[k]), 32'h0);
        end

        // Table: one frame per record, bit_en every 4th cycle, p_ready held high.
        foreach (vecs[v]) begin
            send_frame(vecs[v].idx, vecs[v].data, vecs[v].par, 1'b1, 4);
            chk("tbl_valid", 32'(p_valid[vecs[v].idx]), 32'h1);
            chk("tbl_data",  32'(p_data[vecs[v].idx]), 32'(vecs[v].exp_data));
            chk("tbl_perr",  32'(parity_err[vecs[v].idx]), 32'(vecs[v].exp_perr));
            chk("tbl_ferr",  32'(frame_err[vecs[v].idx]), 32'h0);
            chk("tbl_ovr",   32'(overrun[vecs[v].idx]), 32'h0);
            chk("tbl_busy",  32'(busy[vecs[v].idx]), 32'h0);
            @(negedge clk);
            chk("tbl_valid_1cyc", 32'(p_valid[vecs[v].idx]), 32'h0);
        end

        // Frame error, held-low break, then a clean frame.
        send_frame(0, 8'h77, 1'b0, 1'b0, 4);
        chk("fe_pulse", 32'(frame_err[0]), 32'h1);
        chk("fe_novalid", 32'(p_valid[0]), 32'h0);
        chk("fe_busy", 32'(busy[0]), 32'h1);
        @(negedge clk);
        chk("fe_pulse_end", 32'(frame_err[0]), 32'h0);
        repeat (3) strobe(0, 1'b0, 4);
        chk("brk_busy", 32'(busy[0]), 32'h1);
        chk("brk_novalid", 32'(p_valid[0]), 32'h0);
        strobe(0, 1'b1, 4);
        chk("brk_exit", 32'(busy[0]), 32'h0);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 4);
        chk("fe_next_valid", 32'(p_valid[0]), 32'h1);
        chk("fe_next_data", 32'(p_data[0]), 32'h3C);
        @(negedge clk);

        // Overrun: output register full while a second frame completes.
        p_ready[0] = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b1, 4);
        chk("ov_first", 32'(p_data[0]), 32'h11);
        send_frame(0, 8'h22, 1'b0, 1'b1, 4);
        chk("ov_pulse", 32'(overrun[0]), 32'h1);
        chk("ov_hold_data", 32'(p_data[0]), 32'h11);
        chk("ov_hold_valid", 32'(p_valid[0]), 32'h1);
        @(negedge clk);
        chk("ov_pulse_end", 32'(overrun[0]), 32'h0);
        p_ready[0] = 1'b1;
        @(negedge clk);
        p_ready[0] = 1'b0;
        chk("ov_drained", 32'(p_valid[0]), 32'h0);

        // Accept coinciding with the stop-bit load.
        send_frame(0, 8'h11, 1'b0, 1'b1, 4);
        strobe(0, 1'b0, 4);
        for (int i = 0; i < 8; i++) strobe(0, 1'((8'h22 >> i) & 8'h01), 4);
        strobe(0, 1'b0, 4);
        repeat (3) @(negedge clk);
        s_in[0] = 1'b1;
        bit_en[0] = 1'b1;
        p_ready[0] = 1'b1;
        @(negedge clk);
        bit_en[0] = 1'b0;
        p_ready[0] = 1'b0;
        chk("aal_data", 32'(p_data[0]), 32'h22);
        chk("aal_valid", 32'(p_valid[0]), 32'h1);
        chk("aal_no_ovr", 32'(overrun[0]), 32'h0);
        p_ready[0] = 1'b1;
        @(negedge clk);

        // MSB-first back-to-back with bit_en high every cycle.
        send_frame(2, 8'hC1, 1'b0, 1'b1, 1);
        chk("b2b_first", 32'(p_data[2]), 32'hC1);
        chk("b2b_first_v", 32'(p_valid[2]), 32'h1);
        send_frame(2, 8'h3E, 1'b0, 1'b1, 1);
        chk("b2b_second", 32'(p_data[2]), 32'h3E);
        chk("b2b_second_v", 32'(p_valid[2]), 32'h1);
        @(negedge clk);

        // Reset mid-frame with a word still held.
        p_ready[0] = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b1, 4);
        strobe(0, 1'b0, 4);
        for (int i = 0; i < 4; i++) strobe(0, 1'b1, 4);
        chk("mid_busy", 32'(busy[0]), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_data", 32'(p_data[0]), 32'h0);
        chk("mrst_valid", 32'(p_valid[0]), 32'h0);
        chk("mrst_busy", 32'(busy[0]), 32'h0);
        chk("mrst_perr", 32'(parity_err[0]), 32'h0);
        p_ready[0] = 1'b1;
        send_frame(0, 8'h5A, 1'b0, 1'b1, 4);
        chk("mrst_next_data", 32'(p_data[0]), 32'h5A);
        chk("mrst_next_valid", 32'(p_valid[0]), 32'h1);
        chk("mrst_next_perr", 32'(parity_err[0]), 32'h0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
